// File: rtl/normalize_stage_pkg.sv
// Shared types and constants for the FP adder normalize/pack stage.
package fp_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W-2:0] fraction;
  } result_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/normalize_stage_if.sv
// Upstream operand channel and downstream result channel of the normalize stage.
interface normalize_stage_if #(
  parameter int MANT_W = fp_pkg::MANT_W,
  parameter int EXP_W  = fp_pkg::EXP_W
);

  logic              inValid;
  logic              inReady;
  logic              carryOut;
  logic [MANT_W-1:0] alignedResult;
  logic              alignedSign;
  logic [EXP_W-1:0]  exponentIn;
  logic              bypassIn;
  logic [31:0]       bypassResult;

  logic              outValid;
  logic              outReady;
  logic [31:0]       result;
  logic              overflow;
  logic              underflow;

  modport master (
    output inValid, carryOut, alignedResult, alignedSign, exponentIn,
           bypassIn, bypassResult, outReady,
    input  inReady, outValid, result, overflow, underflow
  );

  modport slave (
    input  inValid, carryOut, alignedResult, alignedSign, exponentIn,
           bypassIn, bypassResult, outReady,
    output inReady, outValid, result, overflow, underflow
  );

endinterface

// File: rtl/normalize_stage_pack.sv
// Combinational packer: assembles {sign, exponent, fraction} and the
// overflow/underflow flags from the normalized sign, exponent and mantissa.
module fp_pack
  import fp_pkg::*;
(
  input  logic              sign_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [MANT_W-1:0] mant_i,
  input  logic              ovf_sel_i,
  input  logic              sub_sel_i,
  output logic [31:0]       word_o,
  output logic              ovf_o,
  output logic              unf_o
);

  result_t packed_r;

  always_comb begin
    packed_r.sign     = sign_i;
    packed_r.exponent = exp_i;
    packed_r.fraction = mant_i[MANT_W-2:0];
    ovf_o             = 1'b0;
    unf_o             = 1'b0;
    if (ovf_sel_i) begin
      packed_r.exponent = EXP_MAX;
      packed_r.fraction = '0;
      ovf_o             = 1'b1;
    end else if (sub_sel_i) begin
      // Subnormal: field 0 encodes the same scale as biased exponent 1.
      packed_r.exponent = '0;
      unf_o             = |mant_i;
    end
  end

  assign word_o = packed_r;

endmodule

// File: rtl/normalize_stage.sv
// Iterative normalizer (one left shift per clock) and packer for the FP adder.
//   state | meaning
//   IDLE  | ready for a new operand set (inReady = 1)
//   SHIFT | shifting mantissa left, decrementing exponent, one step per clock
//   DONE  | packed result valid, held until outReady
module normalize_stage #(
  parameter int MANT_W = fp_pkg::MANT_W,
  parameter int EXP_W  = fp_pkg::EXP_W
) (
  input  logic             clock,
  input  logic             resetN,
  normalize_stage_if.slave bus
);
  import fp_pkg::*;

  localparam logic [EXP_W-1:0] EXP_ONE = 1;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [31:0]       result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [EXP_W:0]    exp_inc;
  logic [MANT_W-1:0] mant_sh;
  logic [EXP_W-1:0]  exp_dec;

  logic              pk_sign;
  logic [EXP_W-1:0]  pk_exp;
  logic [MANT_W-1:0] pk_mant;
  logic              pk_ovf, pk_sub, pk_load, pk_bypass;
  logic [31:0]       pk_word;
  logic              pk_ovf_flag, pk_unf_flag;

  assign exp_inc = {1'b0, bus.exponentIn} + {{EXP_W{1'b0}}, 1'b1};
  assign mant_sh = {mant_q[MANT_W-2:0], 1'b0};
  assign exp_dec = exp_q - EXP_ONE;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mant_d    = mant_q;
    exp_d     = exp_q;
    pk_sign   = sign_q;
    pk_exp    = exp_q;
    pk_mant   = mant_q;
    pk_ovf    = 1'b0;
    pk_sub    = 1'b0;
    pk_load   = 1'b0;
    pk_bypass = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.inValid) begin
          sign_d  = bus.alignedSign;
          mant_d  = bus.alignedResult;
          exp_d   = bus.exponentIn;
          pk_sign = bus.alignedSign;
          pk_mant = bus.alignedResult;
          pk_exp  = bus.exponentIn;
          pk_load = 1'b1;
          state_d = DONE;
          if (bus.bypassIn) begin
            pk_bypass = 1'b1;
          end else if (bus.exponentIn == EXP_MAX ||
                       (bus.carryOut && exp_inc >= {1'b0, EXP_MAX})) begin
            pk_ovf = 1'b1;
          end else if (bus.carryOut) begin
            // Carry renormalizes right by one; the dropped LSB is truncated.
            pk_mant = {1'b1, bus.alignedResult[MANT_W-1:1]};
            pk_exp  = exp_inc[EXP_W-1:0];
          end else if (bus.alignedResult == '0) begin
            pk_sign = 1'b0;
            pk_exp  = '0;
          end else if (bus.alignedResult[MANT_W-1]) begin
            if (bus.exponentIn == '0) pk_exp = EXP_ONE;
          end else if (bus.exponentIn <= EXP_ONE) begin
            pk_sub = 1'b1;
          end else begin
            pk_load = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        mant_d  = mant_sh;
        exp_d   = exp_dec;
        pk_mant = mant_sh;
        pk_exp  = exp_dec;
        if (mant_sh[MANT_W-1]) begin
          pk_load = 1'b1;
          state_d = DONE;
        end else if (exp_dec == EXP_ONE) begin
          pk_load = 1'b1;
          pk_sub  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  fp_pack u_pack (
    .sign_i    (pk_sign),
    .exp_i     (pk_exp),
    .mant_i    (pk_mant),
    .ovf_sel_i (pk_ovf),
    .sub_sel_i (pk_sub),
    .word_o    (pk_word),
    .ovf_o     (pk_ovf_flag),
    .unf_o     (pk_unf_flag)
  );

  always_comb begin
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (pk_load) begin
      result_d = pk_bypass ? bus.bypassResult : pk_word;
      ovf_d    = !pk_bypass && pk_ovf_flag;
      unf_d    = !pk_bypass && pk_unf_flag;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sign_q   <= 1'b0;
      mant_q   <= '0;
      exp_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      sign_q   <= sign_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // inReady is gated by reset so nothing is accepted until resetN releases.
  always_comb begin
    bus.inReady   = resetN && (state_q == IDLE);
    bus.outValid  = (state_q == DONE);
    bus.result    = result_q;
    bus.overflow  = ovf_q;
    bus.underflow = unf_q;
  end

endmodule

// File: tb/tb_normalize_stage.sv
// Directed table-driven bench for normalize_stage plus backpressure and reset sequences.
module tb_normalize_stage;

  typedef struct {
    string       name;
    logic        carry;
    logic [23:0] ar;
    logic        sign;
    logic [7:0]  ex;
    logic        byp;
    logic [31:0] bres;
    logic [31:0] exp_res;
    logic        exp_ovf;
    logic        exp_unf;
    int          exp_k;
  } vec_t;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  normalize_stage_if bus ();

  normalize_stage dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  task automatic add_vec(input string name, input logic carry, input logic [23:0] ar,
                         input logic sign, input logic [7:0] ex, input logic byp,
                         input logic [31:0] bres, input logic [31:0] res,
                         input logic ovf, input logic unf, input int k);
    vec_t v;
    v.name = name; v.carry = carry; v.ar = ar; v.sign = sign; v.ex = ex;
    v.byp = byp; v.bres = bres; v.exp_res = res; v.exp_ovf = ovf;
    v.exp_unf = unf; v.exp_k = k;
    vecs.push_back(v);
  endtask

  // Called #1 after a rising edge with the block idle; returns #1 after the accept edge.
  task automatic launch(input vec_t v);
    bus.carryOut      = v.carry;
    bus.alignedResult = v.ar;
    bus.alignedSign   = v.sign;
    bus.exponentIn    = v.ex;
    bus.bypassIn      = v.byp;
    bus.bypassResult  = v.bres;
    bus.inValid       = 1'b1;
    @(posedge clock);
    #1;
    bus.inValid       = 1'b0;
  endtask

  task automatic await_out(output int cyc);
    cyc = 0;
    while (!bus.outValid && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    vec_t v;

    bus.inValid = 1'b0; bus.carryOut = 1'b0; bus.alignedResult = '0;
    bus.alignedSign = 1'b0; bus.exponentIn = '0; bus.bypassIn = 1'b0;
    bus.bypassResult = '0; bus.outReady = 1'b1;

    //      name            c  ar         s  ex     byp bres          result        ovf unf k
    add_vec("carry_1p1",    1, 24'h000000, 0, 8'd127, 0, 32'h0,        32'h4000_0000, 0, 0, 0);
    add_vec("shift_k2",     0, 24'h200000, 0, 8'd127, 0, 32'h0,        32'h3E80_0000, 0, 0, 2);
    add_vec("cancel",       0, 24'h000000, 1, 8'd127, 0, 32'h0,        32'h0000_0000, 0, 0, 0);
    add_vec("carry_ovf",    1, 24'h000000, 1, 8'd254, 0, 32'h0,        32'hFF80_0000, 1, 0, 0);
    add_vec("subnorm_k2",   0, 24'h000400, 0, 8'd3,   0, 32'h0,        32'h0000_1000, 0, 1, 2);
    add_vec("bypass",       1, 24'h123456, 1, 8'd255, 1, 32'h7FC0_0001, 32'h7FC0_0001, 0, 0, 0);
    add_vec("normalized",   0, 24'hC00000, 1, 8'd130, 0, 32'h0,        32'hC140_0000, 0, 0, 0);
    add_vec("norm_exp0",    0, 24'h800000, 0, 8'd0,   0, 32'h0,        32'h0080_0000, 0, 0, 0);
    add_vec("floor_exp1",   0, 24'h400000, 0, 8'd1,   0, 32'h0,        32'h0040_0000, 0, 1, 0);
    add_vec("exp255",       0, 24'h800000, 0, 8'd255, 0, 32'h0,        32'h7F80_0000, 1, 0, 0);
    add_vec("carry_trunc",  1, 24'hFFFFFF, 0, 8'd100, 0, 32'h0,        32'h32FF_FFFF, 0, 0, 0);
    add_vec("shift_k23",    0, 24'h000001, 0, 8'd127, 0, 32'h0,        32'h3400_0000, 0, 0, 23);
    add_vec("subnorm_k9",   0, 24'h000001, 0, 8'd10,  0, 32'h0,        32'h0000_0200, 0, 1, 9);
    add_vec("carry_254",    1, 24'h000000, 1, 8'd253, 0, 32'h0,        32'hFF00_0000, 0, 0, 0);
    add_vec("shift_to_e1",  0, 24'h400000, 0, 8'd2,   0, 32'h0,        32'h0080_0000, 0, 0, 1);

    // Reset state
    #2;
    check("rst_outValid", 32'(bus.outValid), 32'd0);
    check("rst_inReady", 32'(bus.inReady), 32'd0);
    check("rst_result", bus.result, 32'h0);
    check("rst_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
    @(posedge clock); #1;
    resetN = 1'b1;
    @(posedge clock); #1;
    check("post_rst_inReady", 32'(bus.inReady), 32'd1);

    foreach (vecs[i]) begin
      v = vecs[i];
      launch(v);
      await_out(cyc);
      check({v.name, "_latency"}, 32'(cyc), 32'(v.exp_k));
      check({v.name, "_result"}, bus.result, v.exp_res);
      check({v.name, "_ovf"}, 32'(bus.overflow), 32'(v.exp_ovf));
      check({v.name, "_unf"}, 32'(bus.underflow), 32'(v.exp_unf));
      @(posedge clock); #1;
      check({v.name, "_handshake"}, {30'd0, bus.outValid, bus.inReady}, 32'b01);
    end

    // Backpressure: result held for 5 cycles, no accept
    bus.outReady = 1'b0;
    launch(vecs[1]);
    await_out(cyc);
    check("bp_latency", 32'(cyc), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("bp_result", bus.result, 32'h3E80_0000);
      check("bp_valid_ready", {30'd0, bus.outValid, bus.inReady}, 32'b10);
    end
    bus.outReady = 1'b1;
    @(posedge clock); #1;
    check("bp_release", {30'd0, bus.outValid, bus.inReady}, 32'b01);

    // Reset during SHIFT
    launch(vecs[11]);
    repeat (3) @(posedge clock);
    #1;
    check("shift_busy", 32'(bus.inReady), 32'd0);
    resetN = 1'b0;
    #1;
    check("rst_shift_outs", {bus.result, bus.outValid, bus.inReady, bus.overflow, bus.underflow},
          {32'h0, 4'b0000});
    @(posedge clock); #1;
    resetN = 1'b1;
    @(posedge clock); #1;
    check("rst_shift_idle", {30'd0, bus.outValid, bus.inReady}, 32'b01);

    // Reset during DONE with overflow flag set
    bus.outReady = 1'b0;
    launch(vecs[3]);
    await_out(cyc);
    check("done_ovf", 32'(bus.overflow), 32'd1);
    resetN = 1'b0;
    #1;
    check("rst_done_outs", {bus.result, bus.outValid, bus.inReady, bus.overflow, bus.underflow},
          {32'h0, 4'b0000});
    @(posedge clock); #1;
    resetN = 1'b1;
    bus.outReady = 1'b1;
    @(posedge clock); #1;
    check("rst_done_idle", {30'd0, bus.outValid, bus.inReady}, 32'b01);

    // Recovery after reset
    launch(vecs[4]);
    await_out(cyc);
    check("recover_latency", 32'(cyc), 32'd2);
    check("recover_result", bus.result, 32'h0000_1000);
    @(posedge clock); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
